// File: rtl/sar_search_4bit_pkg.sv
// ---------------------------------------------------------------------------
// sar_search_4bit_pkg
// Shared definitions for the successive-approximation search controller:
//   - sar_state_e  : controller state encoding (IDLE, WAIT, CMP, FIN)
//   - STEPS_W      : width of the step counter reported to the parent
//   - SETTLE_MAX   : largest supported settle delay (cycles)
//   - SETTLE_CNT_W : width of the settle down-counter
// ---------------------------------------------------------------------------
package sar_search_4bit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_CMP  = 2'd2,
      ST_FIN  = 2'd3
   } sar_state_e;

   localparam int STEPS_W      = 3;
   localparam int SETTLE_MAX   = 3;
   localparam int SETTLE_CNT_W = 2;

endpackage

// File: rtl/sar_search_4bit_if.sv
// ---------------------------------------------------------------------------
// sar_search_4bit_if
// Bundle between the search controller and its surroundings.
//   start                  : request a new search (from the parent)
//   eq / gt / sm           : comparator flags for guess vs. target
//   guess                  : trial value, drives comparator operand A
//   busy / done            : search in progress / one-cycle end pulse
//   result / steps / error : outcome of the last search
// Modports:
//   master : parent side (drives start and the comparator flags)
//   slave  : controller side
// ---------------------------------------------------------------------------
interface sar_search_4bit_if
   import sar_search_4bit_pkg::*;
#(
   parameter int WIDTH = 4
) ();

   logic               start;
   logic               eq;
   logic               gt;
   logic               sm;
   logic [WIDTH-1:0]   guess;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   result;
   logic [STEPS_W-1:0] steps;
   logic               error;

   modport master (
      output start, eq, gt, sm,
      input  guess, busy, done, result, steps, error
   );

   modport slave (
      input  start, eq, gt, sm,
      output guess, busy, done, result, steps, error
   );

endinterface

// File: rtl/sar_settle_cnt.sv
// ---------------------------------------------------------------------------
// sar_settle_cnt
// Small loadable down-counter used to hold off flag sampling while the
// comparator settles on a new guess.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload the counter with load_val (has priority)
//   load_val   : reload value
//   tick       : high while the count is zero
// The count stops at zero rather than wrapping.
// ---------------------------------------------------------------------------
module sar_settle_cnt
   import sar_search_4bit_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [SETTLE_CNT_W-1:0] load_val,
   output logic                    tick
);

   logic [SETTLE_CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tick = (cnt_q == '0);

endmodule

// File: rtl/sar_search_4bit.sv
// ---------------------------------------------------------------------------
// sar_search_4bit
// Successive-approximation search controller. Drives a trial value onto a
// magnitude comparator's A operand, reads back Eq/Gt/Sm and bisects the
// range [lo, hi] until Eq is reported, recovering the comparator's B value.
// Inconsistent flags (none or several set, or a step outside the range)
// end the search with error set.
//
// Parameters:
//   WIDTH  : operand width (must match the comparator)
//   SETTLE : extra cycles between a new guess and flag sampling (0..3)
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of sar_search_4bit_if (start, flags in; guess,
//            busy, done, result, steps, error out)
// ---------------------------------------------------------------------------
module sar_search_4bit
   import sar_search_4bit_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   sar_search_4bit_if.slave  bus
);

   // Out-of-range SETTLE values are clamped to what the counter can hold.
   localparam int SETTLE_EFF = (SETTLE > SETTLE_MAX) ? SETTLE_MAX :
                               (SETTLE < 0)          ? 0          : SETTLE;

   // The counter is preloaded with SETTLE-1 so WAIT lasts exactly SETTLE cycles.
   localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD =
      (SETTLE_EFF > 0) ? SETTLE_CNT_W'(SETTLE_EFF - 1) : '0;

   localparam sar_state_e ST_GUESS_NEXT = (SETTLE_EFF > 0) ? ST_WAIT : ST_CMP;

   localparam logic [WIDTH-1:0] MAX_VAL = '1;

   function automatic logic [WIDTH-1:0] mid_point(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      logic [WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[WIDTH:1];
   endfunction

   function automatic logic [STEPS_W-1:0] steps_sat_inc(input logic [STEPS_W-1:0] s);
      return (s == '1) ? s : s + 1'b1;
   endfunction

   sar_state_e         state_q;
   logic [WIDTH-1:0]   lo_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   guess_q;
   logic [WIDTH-1:0]   result_q;
   logic [STEPS_W-1:0] steps_q;
   logic               busy_q;
   logic               done_q;
   logic               error_q;

   logic               settle_tick;

   // Candidate range updates for the two bisection directions. The zero
   // and max guards in the FSM keep the wrapped values from being used.
   logic [WIDTH-1:0]   lo_up;
   logic [WIDTH-1:0]   hi_dn;
   logic [WIDTH-1:0]   mid_after_gt;
   logic [WIDTH-1:0]   mid_after_sm;

   always_comb begin
      lo_up        = guess_q + 1'b1;
      hi_dn        = guess_q - 1'b1;
      mid_after_gt = mid_point(lo_q, hi_dn);
      mid_after_sm = mid_point(lo_up, hi_q);
   end

   sar_settle_cnt u_settle (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state_q != ST_WAIT),
      .load_val (SETTLE_LOAD),
      .tick     (settle_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         lo_q     <= '0;
         hi_q     <= '0;
         guess_q  <= '0;
         result_q <= '0;
         steps_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  lo_q    <= '0;
                  hi_q    <= MAX_VAL;
                  guess_q <= mid_point('0, MAX_VAL);
                  steps_q <= '0;
                  error_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_GUESS_NEXT;
               end
            end

            ST_WAIT: begin
               if (settle_tick) begin
                  state_q <= ST_CMP;
               end
            end

            ST_CMP: begin
               steps_q <= steps_sat_inc(steps_q);
               case ({bus.eq, bus.gt, bus.sm})
                  3'b100: begin
                     result_q <= guess_q;
                     state_q  <= ST_FIN;
                  end

                  3'b010: begin
                     if (guess_q == '0) begin
                        error_q  <= 1'b1;
                        result_q <= guess_q;
                        state_q  <= ST_FIN;
                     end else begin
                        hi_q <= hi_dn;
                        if (lo_q > hi_dn) begin
                           error_q  <= 1'b1;
                           result_q <= guess_q;
                           state_q  <= ST_FIN;
                        end else begin
                           guess_q <= mid_after_gt;
                           state_q <= ST_GUESS_NEXT;
                        end
                     end
                  end

                  3'b001: begin
                     if (guess_q == MAX_VAL) begin
                        error_q  <= 1'b1;
                        result_q <= guess_q;
                        state_q  <= ST_FIN;
                     end else begin
                        lo_q <= lo_up;
                        if (lo_up > hi_q) begin
                           error_q  <= 1'b1;
                           result_q <= guess_q;
                           state_q  <= ST_FIN;
                        end else begin
                           guess_q <= mid_after_sm;
                           state_q <= ST_GUESS_NEXT;
                        end
                     end
                  end

                  default: begin
                     error_q  <= 1'b1;
                     result_q <= guess_q;
                     state_q  <= ST_FIN;
                  end
               endcase
            end

            ST_FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.guess  = guess_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.steps  = steps_q;
   assign bus.error  = error_q;

endmodule
